// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencer for the 5-stage core: merges hazard stalls, redirects and
// data-memory waits into per-stage enables, with a memory watchdog and perf counters.
module pipe_stall_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld_stall,
   input  logic             br_stall,
   input  logic             br_taken,
   input  logic             jump,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_we,
   output logic             ifid_we,
   output logic             ifid_flush,
   output logic             idex_we,
   output logic             idex_bubble,
   output logic             exmem_we,
   output logic             memwb_bubble,
   output logic             busy_wait,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_FAULT} state_t;

   state_t            r_state;
   logic [WAIT_W-1:0] r_wait_cnt;
   logic [CNT_W-1:0]  r_stall_cnt;
   logic [CNT_W-1:0]  r_flush_cnt;
   logic              r_mem_err;

   logic w_freeze;
   logic w_hz;
   logic w_redir;

   // Priority: memory freeze beats hazard stall beats redirect.
   assign w_freeze = ((r_state == S_RUN) & mem_req & ~mem_ready)
                   | ((r_state == S_MEM_WAIT) & ~mem_ready)
                   | (r_state == S_FAULT);
   assign w_hz     = ~w_freeze & (ld_stall | br_stall);
   assign w_redir  = ~w_freeze & ~w_hz & (br_taken | jump);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_RUN;
         r_wait_cnt  <= '0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
         r_mem_err   <= 1'b0;
      end else begin
         if ((w_freeze | w_hz) && (r_state != S_FAULT) && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (w_redir && (r_flush_cnt != '1))
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);

         case (r_state)
            S_RUN: begin
               if (mem_req && !mem_ready) begin
                  r_state    <= S_MEM_WAIT;
                  r_wait_cnt <= WAIT_W'(1);
               end
            end
            S_MEM_WAIT: begin
               if (mem_ready) begin
                  r_state    <= S_RUN;
                  r_wait_cnt <= '0;
               end else if (r_wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
                  r_state   <= S_FAULT;
                  r_mem_err <= 1'b1;
               end else begin
                  r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
               end
            end
            S_FAULT: r_mem_err <= 1'b1;
            default: begin
               r_state   <= S_FAULT;
               r_mem_err <= 1'b1;
            end
         endcase
      end
   end

   // Stage controls take effect in the same cycle; reset forces a safe idle pipe.
   always_comb begin
      pc_we        = 1'b1;
      ifid_we      = 1'b1;
      idex_we      = 1'b1;
      exmem_we     = 1'b1;
      idex_bubble  = 1'b0;
      memwb_bubble = 1'b0;
      ifid_flush   = 1'b0;
      if (rst) begin
         pc_we        = 1'b0;
         ifid_we      = 1'b0;
         idex_we      = 1'b0;
         exmem_we     = 1'b0;
         idex_bubble  = 1'b1;
         memwb_bubble = 1'b1;
      end else if (w_freeze) begin
         pc_we        = 1'b0;
         ifid_we      = 1'b0;
         idex_we      = 1'b0;
         exmem_we     = 1'b0;
         memwb_bubble = 1'b1;
      end else if (w_hz) begin
         pc_we       = 1'b0;
         ifid_we     = 1'b0;
         idex_bubble = 1'b1;
      end else if (w_redir) begin
         ifid_flush = 1'b1;
      end
   end

   assign busy_wait = ~rst & (r_state == S_MEM_WAIT);
   assign mem_err   = r_mem_err;
   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Randomized and directed check of pipe_stall_ctrl against a cycle-level
// behavioural model of the sequencing rules.
module tb_pipe_stall_ctrl;

   localparam int unsigned TMO   = 4;
   localparam int unsigned CW    = 8;
   localparam int          C_MAX = 255;

   logic clk, rst;
   logic ld_stall, br_stall, br_taken, jump, mem_req, mem_ready;
   logic pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_bubble;
   logic busy_wait, mem_err;
   logic [CW-1:0] stall_cnt, flush_cnt;

   int n_total = 0;
   int n_bad   = 0;

   // Model: outstanding-wait bookkeeping and counters
   bit m_fault, m_waiting;
   int m_age, m_stall, m_flush;

   pipe_stall_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) u_dut (
      .clk(clk), .rst(rst),
      .ld_stall(ld_stall), .br_stall(br_stall), .br_taken(br_taken), .jump(jump),
      .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
      .idex_we(idex_we), .idex_bubble(idex_bubble), .exmem_we(exmem_we),
      .memwb_bubble(memwb_bubble), .busy_wait(busy_wait), .mem_err(mem_err),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "bench timeout");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic set_in(input bit ld, input bit bs, input bit bt, input bit jp,
                         input bit mq, input bit mr);
      ld_stall = ld; br_stall = bs; br_taken = bt; jump = jp;
      mem_req = mq; mem_ready = mr;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_we"}, 32'({pc_we, ifid_we, idex_we, exmem_we}), 32'h0);
      check({tag, "_bub"}, 32'({idex_bubble, memwb_bubble, ifid_flush, busy_wait}), 32'hC);
      check({tag, "_err"}, 32'(mem_err), 32'h0);
      check({tag, "_cnt"}, 32'({stall_cnt, flush_cnt}), 32'h0);
   endtask

   // Assert reset between edges, check forced outputs, release with idle inputs.
   task automatic do_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      #1 check_reset_vals("rst_hold");
      set_in(0, 0, 0, 0, 0, 0);
      m_fault = 0; m_waiting = 0; m_age = 0; m_stall = 0; m_flush = 0;
      @(negedge clk);
      #2 rst = 1'b0;
   endtask

   // One clock: drive, compare against model, advance model past the edge.
   task automatic cycle(input bit ld, input bit bs, input bit bt, input bit jp,
                        input bit mq, input bit mr);
      bit frz, hz, rd;
      @(negedge clk);
      set_in(ld, bs, bt, jp, mq, mr);
      #1;
      frz = m_fault || (m_waiting ? !mr : (mq && !mr));
      hz  = !frz && (ld || bs);
      rd  = !frz && !hz && (bt || jp);
      check("pc_we",        32'(pc_we),        32'(!frz && !hz));
      check("ifid_we",      32'(ifid_we),      32'(!frz && !hz));
      check("idex_we",      32'(idex_we),      32'(!frz));
      check("exmem_we",     32'(exmem_we),     32'(!frz));
      check("idex_bubble",  32'(idex_bubble),  32'(hz));
      check("memwb_bubble", 32'(memwb_bubble), 32'(frz));
      check("ifid_flush",   32'(ifid_flush),   32'(rd));
      if (!(m_waiting && mr))
         check("busy_wait", 32'(busy_wait), 32'(m_waiting));
      check("mem_err",      32'(mem_err),      32'(m_fault));
      check("stall_cnt",    32'(stall_cnt),    32'(m_stall));
      check("flush_cnt",    32'(flush_cnt),    32'(m_flush));
      if ((frz || hz) && !m_fault && m_stall < C_MAX) m_stall++;
      if (rd && m_flush < C_MAX) m_flush++;
      if (!m_fault) begin
         if (!m_waiting) begin
            if (mq && !mr) begin
               m_waiting = 1; m_age = 1;
            end
         end else if (mr) begin
            m_waiting = 0;
         end else if (m_age == TMO) begin
            m_waiting = 0; m_fault = 1;
         end else begin
            m_age++;
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      set_in(0, 0, 0, 0, 0, 0);
      #1 check_reset_vals("por");
      do_reset();

      // Load-use stall for one cycle
      cycle(1, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0);
      check("t_ld_stall_cnt", 32'(stall_cnt), 32'd1);
      check("t_ld_pc_we", 32'(pc_we), 32'd1);

      // Branch flush deferred while operands stall
      do_reset();
      cycle(0, 1, 1, 0, 0, 0);
      cycle(0, 1, 1, 0, 0, 0);
      cycle(0, 0, 1, 0, 0, 0);
      check("t_br_flush", 32'(ifid_flush), 32'd1);
      cycle(0, 0, 0, 0, 0, 0);
      check("t_br_cnts", 32'({stall_cnt, flush_cnt}), 32'h0201);

      // Three-cycle memory wait then release
      do_reset();
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, 0);
      cycle(0, 0, 0, 0, 1, 1);
      check("t_mem_release_exmem", 32'(exmem_we), 32'd1);
      cycle(0, 0, 0, 0, 0, 0);
      check("t_mem_stall_cnt", 32'(stall_cnt), 32'd3);
      check("t_mem_busy_after", 32'(busy_wait), 32'd0);

      // Watchdog timeout
      do_reset();
      for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 1, 0);
      cycle(1, 0, 1, 0, 0, 1);
      check("t_tmo_err", 32'(mem_err), 32'd1);
      check("t_tmo_stall", 32'(stall_cnt), 32'd5);
      check("t_tmo_frozen", 32'(pc_we), 32'd0);
      cycle(0, 0, 0, 1, 0, 0);
      do_reset();
      cycle(0, 0, 0, 0, 0, 0);
      check("t_tmo_cleared", 32'({mem_err, stall_cnt}), 32'd0);

      // Reset abandons an in-progress wait
      cycle(0, 0, 0, 0, 1, 0);
      cycle(0, 0, 0, 0, 1, 0);
      do_reset();
      cycle(0, 0, 0, 0, 0, 0);
      check("t_abandon_busy", 32'(busy_wait), 32'd0);
      check("t_abandon_pc_we", 32'(pc_we), 32'd1);

      // Saturation of stall_cnt, then flush_cnt
      do_reset();
      for (int i = 0; i < C_MAX + 15; i++) cycle(1, 0, 0, 0, 0, 0);
      check("t_sat_stall", 32'(stall_cnt), 32'(C_MAX));
      for (int i = 0; i < C_MAX + 15; i++) cycle(0, 0, 0, 1, 0, 0);
      check("t_sat_flush", 32'(flush_cnt), 32'(C_MAX));

      // Randomized traffic with occasional resets to escape FAULT
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         if ((m_fault && $urandom_range(0, 19) == 0) || $urandom_range(0, 399) == 0)
            do_reset();
         cycle($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
               $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
               $urandom_range(0, 2) == 0, $urandom_range(0, 9) < 6);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
